// File: rtl/fb_pkg.sv
// Shared types and default geometry for the framebuffer arbiter and its helpers.
package fb_pkg;

    localparam int DEF_ADDR_W = 12;   // 4096-word image RAM
    localparam int DEF_DATA_W = 1;    // one bit per pixel
    localparam int DEF_IMG_W  = 64;   // pixels per image line (power of 2)
    localparam int DEF_IMG_H  = 64;   // image lines
    localparam int CNT_W      = 10;   // width of the hvsync scan counters

    // Coprocessor access sequencer states.
    typedef enum logic [1:0] {
        CP_IDLE   = 2'd0,
        CP_ACCESS = 2'd1,
        CP_WAIT   = 2'd2,
        CP_ACK    = 2'd3
    } cp_state_t;

    // Owner of the read data returning on mem_rdata.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_CP   = 2'd2
    } tag_t;

endpackage

// File: rtl/fb_disp_addr_gen.sv
// Display slot detection and RAM address generation from the scan counters.
// slot/slot_addr are combinational for the current counter values; slot_q
// marks the following cycle, in which the display read occupies the RAM port.
module fb_disp_addr_gen
    import fb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  counter_x,
    input  logic [CNT_W-1:0]  counter_y,
    output logic              slot,
    output logic [ADDR_W-1:0] slot_addr,
    output logic              slot_q
);

    localparam int X_W = $clog2(IMG_W);
    localparam int Y_W = ADDR_W - X_W;

    // Compare in 32 bits so IMG_W == 1024 does not wrap the 10-bit counter range.
    assign slot = (32'(counter_x) < 32'(IMG_W)) && (32'(counter_y) < 32'(IMG_H));

    // IMG_W is a power of two, so y*IMG_W + x is a plain concatenation.
    assign slot_addr = {counter_y[Y_W-1:0], counter_x[X_W-1:0]};

    // Remember that the RAM port carries a display read in the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q <= 1'b0;
        end else begin
            slot_q <= slot;
        end
    end

endmodule

// File: rtl/framebuffer_arbiter.sv
// Shares the single-port image RAM between VGA scan-out (strict priority,
// fixed 3-cycle latency) and the image coprocessor (req/ack).
//
// Coprocessor handshake: the requester raises cp_req with cp_we/cp_addr/
// cp_wdata stable and holds all of them until it sees the one-cycle cp_ack
// pulse; cp_rdata is valid in that ack cycle for reads. A request presented
// in the cycle directly after an ack is not considered, so a requester that
// drops cp_req on ack is never granted twice.
module framebuffer_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  counter_x,
    input  logic [CNT_W-1:0]  counter_y,
    output logic [DATA_W-1:0] disp_pixel,
    output logic              disp_valid,
    input  logic              cp_req,
    input  logic              cp_we,
    input  logic [ADDR_W-1:0] cp_addr,
    input  logic [DATA_W-1:0] cp_wdata,
    output logic              cp_ack,
    output logic [DATA_W-1:0] cp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output cp_state_t         dbg_state
);

    logic              slot;
    logic [ADDR_W-1:0] slot_addr;
    logic              slot_q;
    cp_state_t         state;
    logic              just_acked;
    tag_t              tag_issue;
    tag_t              tag_data;

    fb_disp_addr_gen #(
        .ADDR_W (ADDR_W),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .counter_x (counter_x),
        .counter_y (counter_y),
        .slot      (slot),
        .slot_addr (slot_addr),
        .slot_q    (slot_q)
    );

    assign dbg_state = state;

    // Coprocessor FSM and RAM port mux; display slots always own the port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CP_IDLE;
            just_acked <= 1'b0;
            cp_ack     <= 1'b0;
            cp_rdata   <= '0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            mem_we     <= 1'b0;
            cp_ack     <= 1'b0;
            just_acked <= 1'b0;
            if (slot) begin
                mem_addr <= slot_addr;
            end
            case (state)
                CP_IDLE: begin
                    if (cp_req && !slot && !just_acked) begin
                        state     <= CP_ACCESS;
                        mem_addr  <= cp_addr;
                        mem_we    <= cp_we;
                        mem_wdata <= cp_wdata;
                    end
                end
                CP_ACCESS: begin
                    if (cp_we) begin
                        state  <= CP_ACK;
                        cp_ack <= 1'b1;
                    end else begin
                        state <= CP_WAIT;
                    end
                end
                CP_WAIT: begin
                    if (tag_data == TAG_CP) begin
                        cp_rdata <= mem_rdata;
                    end
                    state  <= CP_ACK;
                    cp_ack <= 1'b1;
                end
                CP_ACK: begin
                    state      <= CP_IDLE;
                    just_acked <= 1'b1;
                end
                default: state <= CP_IDLE;
            endcase
        end
    end

    // Owner of the access currently on the RAM port (stage 1 of the tag pipe).
    always_comb begin
        tag_issue = TAG_NONE;
        if (slot_q) begin
            tag_issue = TAG_DISP;
        end else if (state == CP_ACCESS) begin
            tag_issue = TAG_CP;
        end
    end

    // Stage 2 of the tag pipe: owner of the data now on mem_rdata.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_data <= TAG_NONE;
        end else begin
            tag_data <= tag_issue;
        end
    end

    // Register display pixels; outside the window the last pixel is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_pixel <= '0;
            disp_valid <= 1'b0;
        end else if (tag_data == TAG_DISP) begin
            disp_pixel <= mem_rdata;
            disp_valid <= 1'b1;
        end else begin
            disp_valid <= 1'b0;
        end
    end

    // A requester must keep cp_req high while its access is in flight.
    req_held_a : assert property (@(posedge clk) disable iff (reset)
        (state == CP_ACCESS || state == CP_WAIT) |-> cp_req);

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Randomised scoreboard bench for framebuffer_arbiter with a RAM macro model.
module tb_framebuffer_arbiter;
  import fb_pkg::*;

  localparam int AW = 12;
  localparam int DW = 1;
  localparam int IW = 64;
  localparam int IH = 64;
  localparam int OUT_X = 100;
  localparam int OUT_Y = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [9:0] counter_x = 10'(OUT_X);
  logic [9:0] counter_y = 10'(OUT_Y);
  logic [DW-1:0] disp_pixel;
  logic disp_valid;
  logic cp_req = 1'b0;
  logic cp_we = 1'b0;
  logic [AW-1:0] cp_addr = '0;
  logic [DW-1:0] cp_wdata = '0;
  logic cp_ack;
  logic [DW-1:0] cp_rdata;
  logic [AW-1:0] mem_addr;
  logic mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  cp_state_t dbg_state;

  framebuffer_arbiter dut (
    .clk(clk), .reset(reset), .counter_x(counter_x), .counter_y(counter_y),
    .disp_pixel(disp_pixel), .disp_valid(disp_valid),
    .cp_req(cp_req), .cp_we(cp_we), .cp_addr(cp_addr), .cp_wdata(cp_wdata),
    .cp_ack(cp_ack), .cp_rdata(cp_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #20 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- RAM macro and reference image ----------------
  logic [DW-1:0] ram [0:4095];
  logic [DW-1:0] ref_mem [0:4095];
  logic do_preload = 1'b0;

  always @(posedge clk) begin
    if (do_preload) begin
      for (int i = 0; i < 4096; i++) ram[i] <= ref_mem[i];
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  // ---------------- scoreboard queues ----------------
  typedef struct { int due; bit vld; logic [DW-1:0] pix; } disp_exp_t;
  typedef struct { int due; logic [AW-1:0] addr; } port_exp_t;
  typedef struct { bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata; int exp_lat; } cp_cmd_t;
  typedef struct { bit rd; logic [DW-1:0] data; int issue; int exp_lat; } cp_exp_t;

  disp_exp_t exp_disp_q[$];
  port_exp_t exp_port_q[$];
  cp_cmd_t   cmd_q[$];
  cp_exp_t   exp_cp_q[$];

  bit busy = 1'b0;
  bit ack_seen = 1'b0;

  // Drive one scan position; the display reference says what must appear 3 cycles later.
  task automatic step(input int x, input int y);
    disp_exp_t d;
    port_exp_t p;
    bit in_win;
    int a;
    @(posedge clk);
    #1;
    counter_x = 10'(x);
    counter_y = 10'(y);
    in_win = (x < IW) && (y < IH);
    a = (y * IW + x) % 4096;
    d.due = cyc + 3;
    d.vld = in_win;
    d.pix = in_win ? ref_mem[a] : '0;
    exp_disp_q.push_back(d);
    if (in_win) begin
      p.due = cyc + 1;
      p.addr = AW'(a);
      exp_port_q.push_back(p);
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(OUT_X, OUT_Y);
  endtask

  task automatic push_cmd(input bit we, input int addr, input logic [DW-1:0] wd, input int lat);
    cp_cmd_t c;
    c.we = we;
    c.addr = AW'(addr);
    c.wdata = wd;
    c.exp_lat = lat;
    cmd_q.push_back(c);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || cmd_q.size() > 0) && n < 400) begin
      step(OUT_X, OUT_Y);
      n++;
    end
    if (busy || cmd_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: cp requests still pending after %0d cycles, expected none", n);
    end
    idle_steps(2);
  endtask

  // ---------------- cp driver: one request at a time, drops req after ack ----------------
  initial begin : cp_agent
    cp_cmd_t c;
    cp_exp_t e;
    int start;
    start = 0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        busy = 1'b0;
        ack_seen = 1'b0;
        cp_req = 1'b0;
        exp_cp_q.delete();
      end else begin
        if (busy && ack_seen) begin
          busy = 1'b0;
          ack_seen = 1'b0;
          cp_req = 1'b0;
        end else if (busy && (cyc - start) > 200) begin
          checks++;
          errors++;
          $display("FAIL cp_timeout: no ack after %0d cycles, expected within %0d", cyc - start, IW + 5);
          busy = 1'b0;
          cp_req = 1'b0;
          exp_cp_q.delete();
        end
        if (!busy && cmd_q.size() > 0) begin
          c = cmd_q.pop_front();
          busy = 1'b1;
          start = cyc;
          cp_req = 1'b1;
          cp_we = c.we;
          cp_addr = c.addr;
          cp_wdata = c.wdata;
          if (c.we) ref_mem[c.addr] = c.wdata;
          e.rd = !c.we;
          e.data = c.we ? '0 : ref_mem[c.addr];
          e.issue = cyc;
          e.exp_lat = c.exp_lat;
          exp_cp_q.push_back(e);
        end
      end
    end
  end

  // ---------------- monitors ----------------
  disp_exp_t md;
  port_exp_t mp;
  always @(negedge clk) begin
    if (reset) begin
      exp_disp_q.delete();
      exp_port_q.delete();
    end else begin
      while (exp_disp_q.size() > 0 && exp_disp_q[0].due < cyc) void'(exp_disp_q.pop_front());
      if (exp_disp_q.size() > 0 && exp_disp_q[0].due == cyc) begin
        md = exp_disp_q.pop_front();
        check("disp_valid", 32'(disp_valid), 32'(md.vld));
        if (md.vld) check("disp_pixel", 32'(disp_pixel), 32'(md.pix));
      end
      while (exp_port_q.size() > 0 && exp_port_q[0].due < cyc) void'(exp_port_q.pop_front());
      if (exp_port_q.size() > 0 && exp_port_q[0].due == cyc) begin
        mp = exp_port_q.pop_front();
        check("disp_mem_addr", 32'(mem_addr), 32'(mp.addr));
        check("disp_mem_we", 32'(mem_we), 32'd0);
      end
    end
  end

  logic ack_prev = 1'b0;
  cp_exp_t me;
  int lat;
  int wait_c;
  always @(negedge clk) begin
    if (reset) begin
      ack_prev = 1'b0;
    end else begin
      if (cp_ack) begin
        ack_seen = 1'b1;
        check("ack_one_cycle", 32'(ack_prev), 32'd0);
        if (exp_cp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cp_unexpected_ack: ack with no request outstanding, expected none");
        end else begin
          me = exp_cp_q.pop_front();
          lat = cyc - me.issue;
          if (me.rd) check("cp_rdata", 32'(cp_rdata), 32'(me.data));
          if (me.exp_lat >= 0) begin
            check("cp_latency", 32'(lat), 32'(me.exp_lat));
          end else begin
            wait_c = lat - (me.rd ? 3 : 2);
            check("cp_wait_bound", 32'(wait_c >= 0 && wait_c <= IW + 1), 32'd1);
          end
        end
      end
      ack_prev = cp_ack;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #(40 * 80000);
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < 4096; i++) ref_mem[i] = DW'($urandom);
    do_preload = 1'b1;
    idle_steps(1);
    do_preload = 1'b0;
    idle_steps(3);

    // Reset state
    check("rst_disp_valid", 32'(disp_valid), 32'd0);
    check("rst_disp_pixel", 32'(disp_pixel), 32'd0);
    check("rst_cp_ack", 32'(cp_ack), 32'd0);
    check("rst_cp_rdata", 32'(cp_rdata), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(CP_IDLE));
    reset = 1'b0;
    idle_steps(3);

    // 1) Reset while a read sits in CP_WAIT: no ack may follow.
    push_cmd(1'b0, 12'h010, '0, -1);
    begin
      int n;
      n = 0;
      step(OUT_X, OUT_Y);
      while (dbg_state != CP_WAIT && n < 10) begin
        step(OUT_X, OUT_Y);
        n++;
      end
      check("t1_reached_wait", 32'(dbg_state), 32'(CP_WAIT));
    end
    reset = 1'b1;
    step(OUT_X, OUT_Y);
    check("t1_cp_ack", 32'(cp_ack), 32'd0);
    check("t1_mem_we", 32'(mem_we), 32'd0);
    check("t1_disp_valid", 32'(disp_valid), 32'd0);
    check("t1_state", 32'(dbg_state), 32'(CP_IDLE));
    step(OUT_X, OUT_Y);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(OUT_X, OUT_Y);
      check("t1_no_ack_after_reset", 32'(cp_ack), 32'd0);
    end

    // 2) Write 1 to 0x0A5 from idle, outside the window.
    step(OUT_X, OUT_Y);
    push_cmd(1'b1, 12'h0A5, 1'b1, 2);
    step(OUT_X, OUT_Y);
    check("t2_mem_we", 32'(mem_we), 32'd1);
    check("t2_mem_addr", 32'(mem_addr), 32'h0A5);
    check("t2_mem_wdata", 32'(mem_wdata), 32'd1);
    step(OUT_X, OUT_Y);
    check("t2_mem_we_single", 32'(mem_we), 32'd0);
    drain();

    // 3) Scan line 5 of the preloaded image.
    for (int x = 0; x < IW; x++) step(x, 5);
    idle_steps(4);

    // 4) Read 0xFFF issued on the last visible pixel of a line.
    step(OUT_X, OUT_Y);
    step(IW - 1, 10);
    push_cmd(1'b0, 12'hFFF, '0, 4);
    step(IW, 10);
    idle_steps(2);
    drain();

    // 5) Full frame with back-to-back random reads.
    for (int y = 0; y < IH + 6; y++) begin
      for (int x = 0; x < IW + 16; x++) begin
        step(x, y);
        if (cmd_q.size() == 0) push_cmd(1'b0, int'($urandom_range(0, 4095)), '0, -1);
      end
    end
    drain();

    // 6) Back-to-back write then read of 0x123.
    v = ~ref_mem[12'h123];
    step(OUT_X, OUT_Y);
    push_cmd(1'b1, 12'h123, v, 2);
    push_cmd(1'b0, 12'h123, '0, 4);
    drain();

    // 7) Random writes outside the window, then reads under random scanning.
    for (int i = 0; i < 24; i++) push_cmd(1'b1, int'($urandom_range(0, 4095)), DW'($urandom), -1);
    drain();
    for (int i = 0; i < 400; i++) begin
      step(int'($urandom_range(0, 99)), int'($urandom_range(0, 69)));
      if (cmd_q.size() == 0) push_cmd(1'b0, int'($urandom_range(0, 4095)), '0, -1);
    end
    drain();
    idle_steps(4);

    check("cp_queue_empty", 32'(exp_cp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
